inverse_viewport_transform: RTL and testbench

- Maps screen-space vertices (x in [0,320], y in [0,240], fp32) back to normalized device coordinates.
- Transforms: x_ndc = (x - 160) / 160, y_ndc = (120 - y) / 120. z and w pass through unchanged.
- Sits between the screen-space picking/raycast front end and NDC-space consumers.
- Unlike the forward transform, it has full valid/ready flow control and an internal output FIFO, so downstream backpressure never drops results from the non-stallable fp32 units.

---
 rtl/inverse_viewport_transform.sv | 245 ++++++++++++++++++++++++
 tb/tb_inverse_viewport_transform.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inverse_viewport_transform.sv
// Screen-space to NDC mapping with valid/ready flow control.
// Pipelined fp32 add/mul lanes feed a credit-protected show-ahead output FIFO.

module fp32_add #(
    parameter int LAT = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_vld,
    output logic [31:0] res
);
    function automatic logic [4:0] lzc(input logic [26:0] v);
        lzc = 5'd0;
        for (int i = 0; i < 27; i++) if (v[i]) lzc = 5'(26 - i);
    endfunction

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up, sg;
    logic [31:0] r, big, sml;
    logic [26:0] ma, mb, sh, n;
    logic [27:0] s;
    logic [7:0] d;
    logic signed [9:0] e;
    logic [4:0] lz;
    logic [24:0] m;

    // Round-to-nearest-even; subnormal inputs and results flush to zero.
    always_comb begin
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        r = '0; big = a; sml = b; ma = '0; mb = '0; sh = '0; n = '0; s = '0;
        d = '0; e = '0; lz = '0; m = '0; up = 1'b0; sg = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) r = 32'h7FC00000;
        else if (a_inf) r = a;
        else if (b_inf) r = b;
        else if (a_zero && b_zero) r = {a[31] & b[31], 31'b0};
        else if (a_zero) r = b;
        else if (b_zero) r = a;
        else begin
            if (a[30:0] < b[30:0]) begin big = b; sml = a; end
            sg = big[31];
            d = big[30:23] - sml[30:23];
            ma = {1'b1, big[22:0], 3'b0};
            mb = {1'b1, sml[22:0], 3'b0};
            if (d >= 8'd27) sh = 27'd1;
            else begin
                sh = mb >> d;
                if ((sh << d) != mb) sh[0] = 1'b1;
            end
            e = $signed({2'b0, big[30:23]});
            s = (big[31] == sml[31]) ? ({1'b0, ma} + {1'b0, sh}) : ({1'b0, ma} - {1'b0, sh});
            if (s != 28'd0) begin
                if (s[27]) begin
                    n = s[27:1] | {26'b0, s[0]};
                    e = e + 10'sd1;
                end else begin
                    lz = lzc(s[26:0]);
                    n = s[26:0] << lz;
                    e = e - $signed({5'b0, lz});
                end
                up = n[2] & (n[1] | n[0] | n[3]);
                m = {1'b0, n[26:3]} + {24'b0, up};
                if (m[24]) e = e + 10'sd1;
                if (e >= 10'sd255) r = {sg, 8'hFF, 23'b0};
                else if (e <= 10'sd0) r = {sg, 31'b0};
                else r = {sg, e[7:0], m[22:0]};
            end
        end
    end

    logic [LAT:1][31:0] dpipe;
    logic [LAT:1]       vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpipe    <= '0;
            vld_pipe <= '0;
        end else begin
            dpipe    <= {dpipe[LAT-1:1], r};
            vld_pipe <= {vld_pipe[LAT-1:1], in_vld};
        end
    end

    assign out_vld = vld_pipe[LAT];
    assign res     = dpipe[LAT];
endmodule

module fp32_mul #(
    parameter int LAT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_vld,
    output logic [31:0] res
);
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st, up, sg;
    logic [31:0] r;
    logic [47:0] p;
    logic [23:0] n;
    logic [24:0] m;
    logic signed [9:0] e;

    always_comb begin
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        sg = a[31] ^ b[31];
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            n = p[47:24]; g = p[23]; st = |p[22:0];
            e = e + 10'sd1;
        end else begin
            n = p[46:23]; g = p[22]; st = |p[21:0];
        end
        up = g & (st | n[0]);
        m = {1'b0, n} + {24'b0, up};
        if (m[24]) e = e + 10'sd1;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = 32'h7FC00000;
        else if (a_inf || b_inf || e >= 10'sd255) r = {sg, 8'hFF, 23'b0};
        else if (a_zero || b_zero || e <= 10'sd0) r = {sg, 31'b0};
        else r = {sg, e[7:0], m[22:0]};
    end

    logic [LAT:1][31:0] dpipe;
    logic [LAT:1]       vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpipe    <= '0;
            vld_pipe <= '0;
        end else begin
            dpipe    <= {dpipe[LAT-1:1], r};
            vld_pipe <= {vld_pipe[LAT-1:1], in_vld};
        end
    end

    assign out_vld = vld_pipe[LAT];
    assign res     = dpipe[LAT];
endmodule

module inverse_viewport_transform #(
    parameter int          FIFO_DEPTH     = 32,
    parameter logic [31:0] NEG_HALF_W     = 32'hC3200000,
    parameter logic [31:0] NEG_HALF_H     = 32'hC2F00000,
    parameter logic [31:0] INV_HALF_W     = 32'h3BCCCCCD,
    parameter logic [31:0] NEG_INV_HALF_H = 32'hBC088889
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0][31:0] vertex_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [3:0][31:0] vertex_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int ZW_STAGES = 16;
    localparam logic [1:0][31:0] OFS = {NEG_HALF_H, NEG_HALF_W};
    localparam logic [1:0][31:0] SCL = {NEG_INV_HALF_H, INV_HALF_W};

    logic          accept, pop, run_q;
    logic [CW-1:0] credit;

    assign accept    = valid_in && ready_out;
    assign pop       = valid_out && ready_in;
    // run_q keeps ready_out low during reset even though credit is zero.
    assign ready_out = run_q && (credit < CW'(FIFO_DEPTH));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_q  <= 1'b0;
            credit <= '0;
        end else begin
            run_q <= 1'b1;
            if (accept && !pop) credit <= credit + CW'(1);
            else if (pop && !accept) credit <= credit - CW'(1);
        end
    end

    logic        add_vld [2];
    logic [31:0] add_res [2];
    logic        mul_vld [2];
    logic [31:0] mul_res [2];

    genvar l;
    generate
        for (l = 0; l < 2; l++) begin : g_lane
            fp32_add #(.LAT(9)) u_add (
                .clk(clk_in), .rst(~rst_n_in), .in_vld(accept),
                .a(vertex_in[l]), .b(OFS[l]), .out_vld(add_vld[l]), .res(add_res[l])
            );
            fp32_mul #(.LAT(7)) u_mul (
                .clk(clk_in), .rst(~rst_n_in), .in_vld(add_vld[l]),
                .a(add_res[l]), .b(SCL[l]), .out_vld(mul_vld[l]), .res(mul_res[l])
            );
        end
    endgenerate

    logic [ZW_STAGES:1][63:0] zw_pipe;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) zw_pipe <= '0;
        else           zw_pipe <= {zw_pipe[ZW_STAGES-1:1], {vertex_in[3], vertex_in[2]}};
    end

    logic             fifo_wr, fifo_empty, fifo_full;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [3:0][31:0] mem [FIFO_DEPTH];

    assign fifo_wr    = mul_vld[0] && mul_vld[1];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fifo_wr) mem[wr_ptr[AW-1:0]] <= {zw_pipe[ZW_STAGES], mul_res[1], mul_res[0]};
    end

    assign valid_out  = !fifo_empty;
    assign vertex_out = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_inverse_viewport_transform.sv
// Directed bench for inverse_viewport_transform: values, latency, flow control, reset.

module tb_inverse_viewport_transform;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_in = 1'b0;
    logic [3:0][31:0] vertex_in = '0;
    logic             ready_out, valid_out;
    logic [3:0][31:0] vertex_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stalls = 0;
    logic [3:0][31:0] outq[$];
    int outc[$];
    int accq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inverse_viewport_transform dut (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .vertex_in(vertex_in), .valid_out(valid_out), .ready_in(ready_in),
        .vertex_out(vertex_out)
    );

    // ulp distance on sign-magnitude keys, so +0 and -0 compare equal
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        longint ko, ke, dd;
        ko = obs[31] ? -longint'(obs[30:0]) : longint'(obs[30:0]);
        ke = exp[31] ? -longint'(exp[30:0]) : longint'(exp[30:0]);
        dd = ko - ke;
        checks++;
        if (dd > tol || dd < -tol) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_in && ready_out) accq.push_back(cyc);
            if (valid_out && ready_in) begin
                outq.push_back(vertex_out);
                outc.push_back(cyc);
            end
            chk("xy_vld_align", {31'b0, dut.mul_vld[0]}, {31'b0, dut.mul_vld[1]}, 0);
            chk("fifo_overflow", {31'b0, dut.fifo_wr & dut.fifo_full}, 32'd0, 0);
        end
    end

    task automatic offer(input logic [3:0][31:0] v);
        int n;
        logic took;
        n = 0;
        valid_in = 1'b1;
        vertex_in = v;
        do begin
            @(negedge clk);
            took = ready_out;
            n++;
            @(posedge clk);
            #1;
        end while (!took && n < 300);
        if (!took) chk("offer_timeout", 32'd0, 32'd1, 0);
        if (n > 1) stalls++;
        valid_in = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k;
        k = 0;
        while (outq.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (outq.size() < n) chk("wait_out", outq.size(), n, 0);
    endtask

    task automatic clear_q();
        outq.delete();
        outc.delete();
        accq.delete();
    endtask

    logic [31:0] vx [7] = '{32'h43200000, 32'h00000000, 32'h43A00000, 32'h42A00000,
                            32'h43700000, 32'h43F00000, 32'h7FC00000};
    logic [31:0] vy [7] = '{32'h42F00000, 32'h00000000, 32'h43700000, 32'h42700000,
                            32'h43340000, 32'hC2F00000, 32'h42F00000};
    logic [31:0] ex [7] = '{32'h00000000, 32'hBF800000, 32'h3F800000, 32'hBF000000,
                            32'h3F000000, 32'h40000000, 32'h7FC00000};
    logic [31:0] ey [7] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h3F000000,
                            32'hBF000000, 32'h40000000, 32'h00000000};
    logic bp_done = 1'b0;

    initial begin
        int bad;
        logic [31:0] nx;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready_out}, 32'd0, 0);
        chk("rst_valid", {31'b0, valid_out}, 32'd0, 0);
        chk("rst_vertex_x", vertex_out[0], 32'd0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", {31'b0, ready_out}, 32'd1, 0);

        // directed values
        ready_in = 1'b1;
        clear_q();
        for (int i = 0; i < 7; i++) offer({32'h3F800000, 32'h3F000000 + i, vy[i], vx[i]});
        wait_out(7, 100);
        if (outq.size() >= 7) begin
            chk("lat_first", outc[0] - accq[0], 32'd17, 0);
            for (int i = 0; i < 7; i++) begin
                if (i == 6) begin
                    nx = outq[i][0];
                    chk("nan_x", {31'b0, (&nx[30:23]) && (|nx[22:0])}, 32'd1, 0);
                end else chk($sformatf("x%0d", i), outq[i][0], ex[i], 1);
                chk($sformatf("y%0d", i), outq[i][1], ey[i], 1);
                chk($sformatf("z%0d", i), outq[i][2], 32'h3F000000 + i, 0);
                chk($sformatf("w%0d", i), outq[i][3], 32'h3F800000, 0);
            end
        end

        // streaming
        repeat (5) @(posedge clk);
        #1;
        clear_q();
        stalls = 0;
        for (int i = 0; i < 100; i++) offer({32'(i + 1000), 32'(i), 32'h42F00000, 32'h43200000});
        wait_out(100, 200);
        chk("stream_stalls", stalls, 32'd0, 0);
        chk("stream_count", outq.size(), 32'd100, 0);
        if (outq.size() >= 100) begin
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                if (outq[i][2] != 32'(i) || outq[i][3] != 32'(i + 1000)) bad++;
                if (i > 0 && outc[i] != outc[i-1] + 1) bad++;
            end
            chk("stream_order_consec", bad, 32'd0, 0);
            chk("stream_lat", outc[0] - accq[0], 32'd17, 0);
            chk("stream_x_last", outq[99][0], 32'h00000000, 1);
        end

        // backpressure, then simultaneous accept/pop at the credit limit
        repeat (5) @(posedge clk);
        #1;
        clear_q();
        ready_in = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) offer({32'h0, 32'(i + 500), 32'h43700000, 32'h43A00000});
                bp_done = 1'b1;
            end
        join_none
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", accq.size(), 32'd32, 0);
        chk("bp_ready_low", {31'b0, ready_out}, 32'd0, 0);
        chk("bp_valid_high", {31'b0, valid_out}, 32'd1, 0);
        chk("bp_credit", {26'b0, dut.credit}, 32'd32, 0);
        ready_in = 1'b1;
        wait_out(40, 300);
        for (int k = 0; k < 50 && !bp_done; k++) @(posedge clk);
        chk("bp_done", {31'b0, bp_done}, 32'd1, 0);
        repeat (5) @(posedge clk);
        chk("bp_count", outq.size(), 32'd40, 0);
        bad = 0;
        foreach (outq[i]) if (outq[i][2] != 32'(i + 500)) bad++;
        chk("bp_order", bad, 32'd0, 0);
        if (outq.size() > 0) chk("bp_x", outq[0][0], 32'h3F800000, 1);

        // reset with results queued and in flight
        #1;
        clear_q();
        ready_in = 1'b0;
        for (int i = 0; i < 6; i++) offer({32'h0, 32'(i + 900), 32'h42F00000, 32'h43200000});
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) offer({32'h0, 32'(i + 950), 32'h42F00000, 32'h43200000});
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'b0, valid_out}, 32'd1, 0);
        ready_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, valid_out}, 32'd0, 0);
        chk("mid_rst_ready", {31'b0, ready_out}, 32'd0, 0);
        chk("mid_rst_vertex", vertex_out[2], 32'd0, 0);
        clear_q();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'b0, ready_out}, 32'd1, 0);
        repeat (40) @(posedge clk);
        chk("no_stale", outq.size(), 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
